clk_div_monitor: RTL and testbench
==================================

Name: clk_div_monitor

Overview:
Clock-rate checker for divided clocks generated elsewhere in the design, such as the divide-by-10 5 MHz output. It samples a slow clock-like input in the clk domain and measures its high and low widths in clk cycles. It checks each width against an expected half-period and reports per-period measurements, errors and a lock indication. Instantiated next to each divider for bring-up and self-check.

Parameters:
EXP_HALF, 5, expected high/low width of clk_in in clk cycles (5 = divide-by-10)
TOL, 0, allowed +/- deviation of each width from EXP_HALF
LOCK_CNT, 4, consecutive good periods required to assert locked
CNT_W, 8, width counter / measurement width; EXP_HALF+TOL+1 < 2^CNT_W

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
clk_in  in  1  monitored divided clock, asynchronous to clk
en  in  1  monitor enable; low forces IDLE
half_hi  out  CNT_W  last captured high width
half_lo  out  CNT_W  last captured low width
meas_valid  out  1  one-cycle pulse: half_hi/half_lo form a complete period
period_err  out  1  one-cycle pulse: width out of tolerance or timeout
locked  out  1  LOCK_CNT consecutive good periods seen, no error since
err_cnt  out  8  saturating error count

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk. All outputs and all internal registers are 0 in reset. Reset mid-operation clears everything immediately.
- Input path: 2-flop synchronizer (s1, s2), then prev <= s2.
- Edge detection: rise = s2 & ~prev; fall = ~s2 & prev.
- Latency: registered outputs update on the 3rd clk edge after clk_in settles before a clk edge.
- run_len counter:
  - on an edge cycle, run_len <= 1; otherwise run_len <= run_len+1, saturating at all-ones.
  - The captured width is the run_len value before the update. A level held 5 cycles captures 5.
- width_ok = (w >= EXP_HALF-TOL) && (w <= EXP_HALF+TOL). The lower bound clamps at 0.
- FSM states: IDLE, SYNC, MEAS, LOCK.
  - IDLE: entered whenever en=0 (overrides every other transition).
    - locked=0; good-period count, have_hi and run_len cleared.
    - half_hi, half_lo and err_cnt retain their values.
    - en=1 -> SYNC.
  - SYNC: waits for any edge. The first edge is not captured because its width is partial; have_hi=0, -> MEAS.
  - MEAS/LOCK, on fall:
    - half_hi <= width; hi_ok <= width_ok; have_hi <= 1.
    - If !width_ok: period_err pulse, good count <= 0, -> MEAS.
  - MEAS/LOCK, on rise:
    - half_lo <= width.
    - If !width_ok: period_err pulse, good count <= 0, -> MEAS.
    - If have_hi: meas_valid pulses in the same cycle half_lo updates.
    - If have_hi and hi_ok and width_ok: good count += 1, saturating at LOCK_CNT.
    - When the good count reaches LOCK_CNT: -> LOCK and locked <= 1 on that edge.
  - A bad width while in LOCK: locked <= 0 on the same edge that pulses period_err.
- Timeout:
  - Condition: in MEAS/LOCK with no edge and run_len == EXP_HALF+TOL+1.
  - Response: period_err pulse, locked <= 0, good count <= 0, have_hi <= 0, -> SYNC.
  - Fires once per stuck level. SYNC does not time out.
- err_cnt increments on every period_err pulse and saturates at 255. Cleared only by reset.
- meas_valid and period_err may pulse in the same cycle, e.g. a bad low width with have_hi=1.
- en falling while an edge is detected: IDLE wins; no capture, no pulse.

Test Plan:
1. clk_in = 5 high/5 low synchronous to clk, EXP_HALF=5, TOL=0, en=1 -> first meas_valid with half_hi=5, half_lo=5; locked rises with the 4th meas_valid; period_err never asserts; err_cnt=0.
2. While locked, stretch one high phase to 7 -> period_err pulse at that fall capture, locked drops the same cycle, err_cnt=1; half_hi=7 on the next meas_valid; locked reasserts after 4 further good periods.
3. While locked, hold clk_in high -> single period_err when run_len hits 6, FSM -> SYNC, err_cnt=1, no further pulses while stuck; resume toggling -> first partial width discarded, relock after 4 periods.
4. TOL=1, clk_in alternating 4 high/6 low -> no period_err; meas_valid shows half_hi=4, half_lo=6; locked after 4 periods. Same bench with 3 high -> period_err.
5. Deassert en while locked -> locked=0 next cycle, no meas_valid/period_err while en=0, half_hi/half_lo unchanged; reassert en -> SYNC, relock; asynchronously assert rst_n=0 mid-period -> all outputs 0 immediately.
6. Force 300 bad widths (clk_in 2 high/2 low) -> err_cnt saturates at 255, locked stays 0.

Source files
------------

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures high/low widths of a divided clock, flags bad periods and reports lock
module clk_div_monitor #(
  parameter int EXP_HALF = 5,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_in,
  input  logic             en,
  output logic [CNT_W-1:0] half_hi,
  output logic [CNT_W-1:0] half_lo,
  output logic             meas_valid,
  output logic             period_err,
  output logic             locked,
  output logic [7:0]       err_cnt
);
  localparam int LO_B = (EXP_HALF > TOL) ? EXP_HALF - TOL : 0;
  localparam int HI_B = EXP_HALF + TOL;
  localparam int GW   = $clog2(LOCK_CNT + 1);
  typedef enum logic [1:0] {IDLE, SYNC, MEAS, LOCK} state_t;
  state_t state_q, state_d;
  logic s1_q, s2_q, prev_q;
  logic [CNT_W-1:0] run_q, run_d, hi_q, hi_d, lo_q, lo_d;
  logic [GW-1:0] good_q, good_d;
  logic have_hi_q, have_hi_d, hi_ok_q, hi_ok_d, mv_q, mv_d, pe_q, pe_d;
  logic [7:0] ec_q, ec_d;
  logic rise, fall, edge_det, ok, active, tmo;
  assign rise     = s2_q & ~prev_q;
  assign fall     = ~s2_q & prev_q;
  assign edge_det = rise | fall;
  assign ok       = (run_q >= CNT_W'(LO_B)) && (run_q <= CNT_W'(HI_B));
  assign active   = (state_q == MEAS) || (state_q == LOCK);
  assign tmo      = active && !edge_det && (run_q == CNT_W'(HI_B + 1));
  assign half_hi    = hi_q;
  assign half_lo    = lo_q;
  assign meas_valid = mv_q;
  assign period_err = pe_q;
  assign locked     = (state_q == LOCK);
  assign err_cnt    = ec_q;
  // bring the asynchronous clk_in into the clk domain and keep one delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= clk_in;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end
  // next state: IDLE overrides all, SYNC discards the first partial level, timeout beats edge handling
  always_comb begin
    state_d   = state_q;
    run_d     = edge_det ? CNT_W'(1) : (&run_q ? run_q : run_q + 1'b1);
    hi_d      = hi_q;
    lo_d      = lo_q;
    good_d    = good_q;
    have_hi_d = have_hi_q;
    hi_ok_d   = hi_ok_q;
    mv_d      = 1'b0;
    pe_d      = 1'b0;
    if (!en) begin
      state_d   = IDLE;
      run_d     = '0;
      good_d    = '0;
      have_hi_d = 1'b0;
    end else if (state_q == IDLE) begin
      state_d = SYNC;
      run_d   = '0;
    end else if (state_q == SYNC) begin
      state_d   = edge_det ? MEAS : SYNC;
      have_hi_d = edge_det ? 1'b0 : have_hi_q;
    end else if (tmo) begin
      pe_d      = 1'b1;
      good_d    = '0;
      have_hi_d = 1'b0;
      state_d   = SYNC;
    end else if (fall) begin
      hi_d      = run_q;
      hi_ok_d   = ok;
      have_hi_d = 1'b1;
      if (!ok) begin
        pe_d    = 1'b1;
        good_d  = '0;
        state_d = MEAS;
      end
    end else if (rise) begin
      lo_d = run_q;
      mv_d = have_hi_q;
      if (!ok) begin
        pe_d    = 1'b1;
        good_d  = '0;
        state_d = MEAS;
      end else if (have_hi_q && hi_ok_q) begin
        good_d  = (good_q == GW'(LOCK_CNT)) ? good_q : good_q + 1'b1;
        state_d = (good_d == GW'(LOCK_CNT)) ? LOCK : state_q;
      end
    end
    ec_d = (pe_d && ec_q != 8'hff) ? ec_q + 8'd1 : ec_q;
  end
  // register measurement state and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      run_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      good_q    <= '0;
      have_hi_q <= 1'b0;
      hi_ok_q   <= 1'b0;
      mv_q      <= 1'b0;
      pe_q      <= 1'b0;
      ec_q      <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      good_q    <= good_d;
      have_hi_q <= have_hi_d;
      hi_ok_q   <= hi_ok_d;
      mv_q      <= mv_d;
      pe_q      <= pe_d;
      ec_q      <= ec_d;
    end
  end
endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor: table-driven period stimulus with a queue scoreboard plus corner-case sequences
module tb_clk_div_monitor;
  logic clk = 1'b0;
  logic rst_n, clk_in, en0, en1;
  logic [7:0] hh0, hl0, ec0, hh1, hl1, ec1;
  logic mv0, pe0, lk0, mv1, pe1, lk1;
  typedef struct packed {logic [7:0] hi; logic [7:0] lo; logic lk; logic er;} exp_t;
  typedef struct {int hi; int lo; logic lk; logic er;} vec_t;
  exp_t sb[$];
  exp_t e;
  vec_t tbl[17];
  int n_chk = 0, n_err = 0, n_pe0 = 0, n_mv1 = 0, n_pe1 = 0;
  logic lk1_seen = 1'b0;
  logic [7:0] f_hi1 = '0, f_lo1 = '0;

  always #5 clk = ~clk;

  clk_div_monitor u0 (
    .clk(clk), .rst_n(rst_n), .clk_in(clk_in), .en(en0),
    .half_hi(hh0), .half_lo(hl0), .meas_valid(mv0), .period_err(pe0),
    .locked(lk0), .err_cnt(ec0)
  );

  clk_div_monitor #(.TOL(1)) u1 (
    .clk(clk), .rst_n(rst_n), .clk_in(clk_in), .en(en1),
    .half_hi(hh1), .half_lo(hl1), .meas_valid(mv1), .period_err(pe1),
    .locked(lk1), .err_cnt(ec1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    clk_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic per(input int hi, input int lo, input logic lk, input logic er);
    hold(1'b1, hi);
    hold(1'b0, lo);
    sb.push_back(exp_t'({8'(hi), 8'(lo), lk, er}));
  endtask

  task automatic run_tbl(input int a, input int b);
    for (int i = a; i <= b; i++) per(tbl[i].hi, tbl[i].lo, tbl[i].lk, tbl[i].er);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (pe0) n_pe0++;
      if (mv0) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL meas0 unexpected: hi %0d lo %0d", hh0, hl0);
        end else begin
          e = sb.pop_front();
          chk("meas0 {hi,lo,lk,err}", {14'd0, hh0, hl0, lk0, pe0}, {14'd0, e.hi, e.lo, e.lk, e.er});
        end
      end
      if (pe1) n_pe1++;
      if (mv1) begin
        if (n_mv1 == 0) begin
          f_hi1 = hh1;
          f_lo1 = hl1;
        end
        n_mv1++;
      end
      if (lk1) lk1_seen = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 17; i++) tbl[i] = '{5, 5, 1'b0, 1'b0};
    tbl[3].lk  = 1'b1;
    tbl[4].lk  = 1'b1;
    tbl[5]     = '{6, 5, 1'b0, 1'b0};
    tbl[9].lk  = 1'b1;
    tbl[10]    = '{5, 4, 1'b0, 1'b1};
    tbl[11]    = '{5, 6, 1'b0, 1'b1};
    tbl[12]    = '{4, 5, 1'b0, 1'b0};
    tbl[16].lk = 1'b1;
    rst_n = 1'b0;
    en0 = 1'b0;
    en1 = 1'b0;
    clk_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset0", {5'd0, hh0, hl0, ec0, mv0, pe0, lk0}, 32'd0);
    chk("reset1", {5'd0, hh1, hl1, ec1, mv1, pe1, lk1}, 32'd0);
    rst_n = 1'b1;
    en0 = 1'b1;
    hold(1'b0, 3);
    run_tbl(0, 16);
    hold(1'b1, 4);
    #1;
    chk("tbl_locked", lk0, 1);
    chk("tbl_err_cnt", ec0, 4);
    chk("tbl_pe_pulses", n_pe0, 4);
    hold(1'b1, 20);
    #1;
    chk("tmo_pe_pulses", n_pe0, 5);
    chk("tmo_err_cnt", ec0, 5);
    chk("tmo_locked", lk0, 0);
    hold(1'b0, 5);
    run_tbl(13, 16);
    hold(1'b1, 4);
    #1;
    chk("relock_locked", lk0, 1);
    chk("relock_err_cnt", ec0, 5);
    en0 = 1'b0;
    @(negedge clk);
    #1;
    chk("en_off_locked", lk0, 0);
    repeat (3) begin
      hold(1'b1, 5);
      hold(1'b0, 5);
    end
    hold(1'b0, 10);
    #1;
    chk("idle_pe_pulses", n_pe0, 5);
    chk("idle_halves", {hh0, hl0}, {8'd5, 8'd5});
    chk("idle_err_cnt", ec0, 5);
    en0 = 1'b1;
    hold(1'b0, 3);
    run_tbl(13, 16);
    hold(1'b1, 4);
    #1;
    chk("en_on_locked", lk0, 1);
    chk("en_on_pe_pulses", n_pe0, 5);
    hold(1'b1, 2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {5'd0, hh0, hl0, ec0, mv0, pe0, lk0}, 32'd0);
    en0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    en1 = 1'b1;
    hold(1'b0, 3);
    repeat (6) begin
      hold(1'b1, 4);
      hold(1'b0, 6);
    end
    hold(1'b1, 3);
    hold(1'b0, 6);
    hold(1'b1, 5);
    #1;
    chk("tol_first_meas", {f_hi1, f_lo1}, {8'd4, 8'd6});
    chk("tol_locked_seen", lk1_seen, 1);
    chk("tol_meas_count", n_mv1, 7);
    chk("tol_pe_pulses", n_pe1, 1);
    chk("tol_err_cnt", ec1, 1);
    chk("tol_locked_after_bad", lk1, 0);
    chk("tol_last_halves", {hh1, hl1}, {8'd3, 8'd6});
    en1 = 1'b0;
    hold(1'b0, 3);
    en0 = 1'b1;
    hold(1'b0, 3);
    repeat (300) per(2, 2, 1'b0, 1'b1);
    hold(1'b1, 4);
    #1;
    chk("sat_err_cnt", ec0, 255);
    chk("sat_locked", lk0, 0);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
